phase_seq_monitor: RTL and testbench
====================================

// Module: phase_seq_monitor
// PURPOSE
//   Consumes the 3-bit phase code from the free-running 4-phase sequencer FSM
//   (legal codes 0,1,2,3, advancing by one each sample, 3 wraps to 0).
//   Checks every valid sample against the expected next phase, counts completed
//   sequences and errors, and asserts lock after LOCK_CYCLES consecutive clean
//   sequences. Sits directly downstream of the sequencer; its outputs feed status/CSR logic.
// PARAMETERS
//   LOCK_CYCLES  4  clean wraps (3->0) required in ACQUIRE before locked asserts; >=1
//   CNT_W        8  width of cycle_count (wraps modulo 2^CNT_W)
//   ERR_W        4  width of err_count (saturates at all-ones)
// PORTS
//   clk          in   1      clock, all logic on rising edge
//   reset        in   1      asynchronous, active-high; clock clk
//   phase_in     in   3      phase code from sequencer; 3'b1xx is illegal
//   phase_valid  in   1      sample phase_in this cycle (tie 1 for free-running source)
//   clr          in   1      synchronous clear of cycle_count and err_count
//   locked       out  1      level: FSM in LOCKED
//   seq_err      out  1      1-cycle pulse: illegal code or out-of-sequence sample
//   cycle_done   out  1      1-cycle pulse: valid 3->0 wrap accepted
//   cycle_count  out  CNT_W  number of accepted wraps, modulo 2^CNT_W
//   err_count    out  ERR_W  number of seq_err pulses, saturating
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, prev=0, good_cnt=0, all outputs 0.
//   - All outputs registered; respond on the edge that samples the input (1-cycle latency).
//   - phase_valid=0: no check, state/prev/counters hold, pulses 0; phase_in ignored.
//   - expected = (prev+1) mod 4. A repeated phase is a mismatch.
//   - States:
//     IDLE: legal sample -> prev=sample, good_cnt=0, go ACQUIRE; illegal -> seq_err, stay.
//     ACQUIRE: sample==expected -> prev=sample; if prev==3 and sample==0: cycle_done,
//       cycle_count+1, good_cnt+1; when good_cnt reaches LOCK_CYCLES -> LOCKED
//       (locked=1 on that same edge).
//       Legal mismatch -> seq_err, good_cnt=0, prev=sample (resync), stay ACQUIRE.
//       Illegal -> seq_err, good_cnt=0, go IDLE.
//     LOCKED: match -> as ACQUIRE (cycle_done/cycle_count), good_cnt held.
//       Legal mismatch -> seq_err, good_cnt=0, prev=sample, go ACQUIRE, locked=0 same edge.
//       Illegal -> seq_err, go IDLE, locked=0.
//   - err_count += 1 on every seq_err, saturating at 2^ERR_W-1.
//   - cycle_count wraps to 0 after 2^CNT_W-1.
//   - clr: cycle_count=0, err_count=0 on that edge; clr wins over a simultaneous increment;
//     pulses and FSM unaffected.
//   - good_cnt width: $clog2(LOCK_CYCLES+1).
// TESTING
//   1. Reset, phase_valid=1, stream 0,1,2,3,... from sample 0 -> cycle_done after samples
//      4,8,12,16; locked=1 on edge of sample 16; cycle_count=4; seq_err never.
//   2. Locked, feed 2 where 1 expected -> seq_err 1 cycle, locked=0, err_count=1;
//      continue 3,0 -> cycle_done, still ACQUIRE; 4 clean wraps later locked=1 again.
//   3. ACQUIRE, feed 3'b101 -> seq_err, state IDLE, err_count+1; next 0 -> ACQUIRE, no error.
//   4. phase_valid=0 for 3 cycles with phase_in=3'b111 mid-sequence, then resume
//      expected value -> no seq_err, counters unchanged during gap.
//   5. 20 forced errors, ERR_W=4 -> err_count=15; clr asserted on a cycle_done edge
//      -> cycle_count=0, err_count=0, cycle_done still pulses.
//   6. Assert reset asynchronously mid-LOCKED (between edges) -> locked, counts, pulses 0
//      immediately; after release, relock takes full LOCK_CYCLES again.

Source files
------------

// File: rtl/phase_seq_monitor.sv
// Checks a 4-phase sequencer code stream, counting wraps and errors and flagging lock.
// Latency: 1 cycle (all outputs registered); no backpressure, samples gated by phase_valid.
module phase_seq_monitor #(
  parameter int LOCK_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       phase_in,
  input  logic             phase_valid,
  input  logic             clr,
  output logic             locked,
  output logic             seq_err,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic [1:0]    prev;
  logic [GW-1:0] good_cnt;

  logic          legal;
  logic          match;
  logic          err_ev;
  logic          done_ev;
  logic [1:0]    expected;
  logic [GW-1:0] good_inc;

  always_comb begin
    legal    = ~phase_in[2];
    expected = prev + 2'd1;
    match    = legal && (phase_in[1:0] == expected);
    err_ev   = phase_valid && (!legal || (state != IDLE && !match));
    // A match with prev==3 can only be a 3->0 wrap.
    done_ev  = phase_valid && (state != IDLE) && match && (prev == 2'd3);
    good_inc = good_cnt + GW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prev        <= 2'd0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      seq_err    <= err_ev;
      cycle_done <= done_ev;

      if (clr)
        cycle_count <= '0;
      else if (done_ev)
        cycle_count <= cycle_count + CNT_W'(1);

      if (clr)
        err_count <= '0;
      else if (err_ev && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);

      if (phase_valid) begin
        case (state)
          IDLE: begin
            if (legal) begin
              prev     <= phase_in[1:0];
              good_cnt <= '0;
              state    <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (!legal) begin
              good_cnt <= '0;
              state    <= IDLE;
            end else if (match) begin
              prev <= phase_in[1:0];
              if (prev == 2'd3) begin
                good_cnt <= good_inc;
                if (good_inc == GW'(LOCK_CYCLES)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end
            end else begin
              // Resynchronise on the observed phase.
              good_cnt <= '0;
              prev     <= phase_in[1:0];
            end
          end
          LOCKED: begin
            if (!legal) begin
              good_cnt <= '0;
              state    <= IDLE;
              locked   <= 1'b0;
            end else if (match) begin
              prev <= phase_in[1:0];
            end else begin
              good_cnt <= '0;
              prev     <= phase_in[1:0];
              state    <= ACQUIRE;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_seq_monitor.sv
// Bench for phase_seq_monitor: table-driven vectors through an expected-result queue.
module tb_phase_seq_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] phase_in;
  logic       phase_valid;
  logic       clr;
  logic       locked;
  logic       seq_err;
  logic       cycle_done;
  logic [7:0] cycle_count;
  logic [3:0] err_count;

  phase_seq_monitor #(.LOCK_CYCLES(4), .CNT_W(8), .ERR_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .clr         (clr),
    .locked      (locked),
    .seq_err     (seq_err),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [2:0] ph;
    logic       vld;
    logic       c;
    logic       lk;
    logic       err;
    logic       dn;
    logic [7:0] cc;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(int tag, int ph, logic vld, logic c,
                              logic lk, logic err, logic dn, int cc, int ec);
    vec_t v;
    v.tag = tag;
    v.ph  = 3'(ph);
    v.vld = vld;
    v.c   = c;
    v.lk  = lk;
    v.err = err;
    v.dn  = dn;
    v.cc  = 8'(cc);
    v.ec  = 4'(ec);
    tbl.push_back(v);
  endfunction

  task automatic check_outs(int tag, int idx, logic lk, logic err, logic dn,
                            logic [7:0] cc, logic [3:0] ec);
    n_checks++;
    if ({locked, seq_err, cycle_done, cycle_count, err_count} !== {lk, err, dn, cc, ec}) begin
      n_fail++;
      $display("FAIL test%0d vec%0d: got lk=%b err=%b dn=%b cc=%0d ec=%0d, want lk=%b err=%b dn=%b cc=%0d ec=%0d",
               tag, idx, locked, seq_err, cycle_done, cycle_count, err_count,
               lk, err, dn, cc, ec);
    end
  endtask

  task automatic run_table();
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      phase_in    = tbl[i].ph;
      phase_valid = tbl[i].vld;
      clr         = tbl[i].c;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_outs(e.tag, i, e.lk, e.err, e.dn, e.cc, e.ec);
    end
    tbl.delete();
  endtask

  // Clean stream from reset: wraps on samples 4,8,12,16, lock on the 16th.
  function automatic void fill_clean_start(int tag);
    for (int i = 0; i <= 16; i++)
      add(tag, i % 4, 1'b1, 1'b0, (i == 16), 1'b0, (i > 0 && i % 4 == 0), i / 4, 0);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    phase_in    = 3'd0;
    phase_valid = 1'b0;
    clr         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs(0, 0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    fill_clean_start(1);

    // Locked, out-of-order 2 instead of 1, then relock after the required wraps.
    add(2, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
    add(2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1);
    add(2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5, 1);
    for (int w = 1; w <= 3; w++) begin
      for (int p = 1; p <= 3; p++)
        add(2, p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4 + w, 1);
      add(2, 0, 1'b1, 1'b0, (w == 3), 1'b0, 1'b1, 5 + w, 1);
    end

    // Repeated phase unlocks; illegal codes drop to IDLE and stay there.
    add(3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8, 2);
    add(3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 2);
    add(3, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8, 3);
    add(3, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8, 4);
    add(3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4);
    add(3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4);
    add(3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4);

    // Invalid gap with an illegal code on the bus, then resume.
    for (int g = 0; g < 3; g++)
      add(4, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4);
    add(4, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 4);
    add(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9, 4);

    // 20 forced errors saturate err_count, then clr on a wrap edge.
    for (int k = 1; k <= 20; k++)
      add(5, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9, (4 + k > 15) ? 15 : 4 + k);
    add(5, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 15);
    add(5, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 15);
    add(5, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9, 15);
    add(5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);

    // cycle_count rolls over past 255; lock returns after the 4th clean wrap.
    for (int j = 1; j <= 257; j++) begin
      for (int p = 1; p <= 3; p++)
        add(7, p, 1'b1, 1'b0, (j >= 4), 1'b0, 1'b0, (j - 1) % 256, 0);
      add(7, 0, 1'b1, 1'b0, (j >= 3), 1'b0, 1'b1, j % 256, 0);
    end

    run_table();

    // Asynchronous reset between edges while locked and cycle_done is high.
    #2;
    reset       = 1'b1;
    phase_valid = 1'b0;
    #1;
    check_outs(6, 0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    @(posedge clk);
    #1;
    check_outs(6, 1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    fill_clean_start(8);
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
